hazard_ctrl: RTL

Parametrised forwarding and interlock controller for the five-stage integer pipeline. It sits beside the decode stage and compares the decoding instruction's source registers against the destinations of older instructions in EX and MEM. From that it produces operand-forwarding selects and a decode stall. It also keeps a scoreboard for one non-pipelined multi-cycle unit (multiply/divide) and stalls decode on RAW, WAW and structural hazards against it.

---
 rtl/hazard_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage forwarding selects and interlock for the
// five-stage integer pipeline, plus a scoreboard for the single
// non-pipelined multi-cycle (mul/div) unit.
//
// Decode handshake: decode presents an instruction with id_valid; ~stall
// is the ready side. The instruction leaves decode on a cycle where
// id_valid & ~stall. A multi-cycle op is accepted (mc_issue) on exactly
// such a cycle. While stall=1 the decode inputs must be held stable.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MC_LAT   = 4,
  parameter int ZERO_REG = 1,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs_addr,
  input  logic                id_rs_read,
  input  logic [REG_AW-1:0]   id_rt_addr,
  input  logic                id_rt_read,
  input  logic                id_wr_en,
  input  logic [REG_AW-1:0]   id_wr_addr,
  input  logic                id_mc,
  input  logic                ex_wr_en,
  input  logic [REG_AW-1:0]   ex_wr_addr,
  input  logic                ex_is_load,
  input  logic                mem_wr_en,
  input  logic [REG_AW-1:0]   mem_wr_addr,
  input  logic                mem_is_load,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall,
  output logic                mc_issue,
  output logic                mc_busy,
  output logic [REG_AW-1:0]   mc_dst,
  output logic                mc_done,
  output logic [STALL_CW-1:0] stall_cnt
);

  // Forward select encoding
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EX    = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_MEMLD = 2'b11;

  // Latency as loaded into the 4-bit countdown
  localparam logic [3:0] LAT = 4'(MC_LAT);

  // Scoreboard state
  logic                busy_q, busy_d;
  logic [REG_AW-1:0]   dst_q, dst_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

  // Per-source match terms
  logic rs_ex_m, rs_mem_m, rs_mc_m;
  logic rt_ex_m, rt_mem_m, rt_mc_m;

  // Hazard terms
  logic load_use, raw_mc, waw_mc, struct_mc;
  logic stall_int, issue_int, done_int;
  logic [1:0] fwd_a_int, fwd_b_int;

  // A source matches a producer when both sides are live, addresses are
  // equal, and the address is not the hardwired zero register.
  function automatic logic src_match(
    input logic              rd,
    input logic              we,
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst
  );
    logic is_zero;
    is_zero   = (ZERO_REG != 0) && (src == '0);
    src_match = rd && we && (src == dst) && !is_zero;
  endfunction

  // EX is the youngest producer and wins over MEM. A load in EX has no
  // data yet, so it yields no forward (the load-use stall covers it).
  function automatic logic [1:0] fwd_sel(
    input logic ex_m,
    input logic ex_ld,
    input logic mem_m,
    input logic mem_ld
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_m && !ex_ld) begin
      sel = FWD_EX;
    end else if (ex_m && ex_ld) begin
      sel = FWD_RF;
    end else if (mem_m) begin
      sel = mem_ld ? FWD_MEMLD : FWD_MEM;
    end
    return sel;
  endfunction

  // Source-versus-producer comparisons for EX, MEM and the in-flight op
  always_comb begin
    rs_ex_m  = src_match(id_rs_read, ex_wr_en,  id_rs_addr, ex_wr_addr);
    rs_mem_m = src_match(id_rs_read, mem_wr_en, id_rs_addr, mem_wr_addr);
    rs_mc_m  = src_match(id_rs_read, busy_q,    id_rs_addr, dst_q);
    rt_ex_m  = src_match(id_rt_read, ex_wr_en,  id_rt_addr, ex_wr_addr);
    rt_mem_m = src_match(id_rt_read, mem_wr_en, id_rt_addr, mem_wr_addr);
    rt_mc_m  = src_match(id_rt_read, busy_q,    id_rt_addr, dst_q);
  end

  // Forward selects, stall and issue decisions
  always_comb begin
    fwd_a_int = fwd_sel(rs_ex_m, ex_is_load, rs_mem_m, mem_is_load);
    fwd_b_int = fwd_sel(rt_ex_m, ex_is_load, rt_mem_m, mem_is_load);

    load_use  = ex_is_load && (rs_ex_m || rt_ex_m);
    raw_mc    = busy_q && (rs_mc_m || rt_mc_m);
    waw_mc    = busy_q && id_wr_en && (id_wr_addr == dst_q);
    struct_mc = busy_q && id_mc;

    stall_int = id_valid && (load_use || raw_mc || waw_mc || struct_mc);
    issue_int = id_valid && id_mc && !stall_int;
    done_int  = busy_q && (cnt_q == 4'd1);
  end

  // Outputs; everything combinational is forced quiet during reset
  always_comb begin
    fwd_a     = rst ? FWD_RF : fwd_a_int;
    fwd_b     = rst ? FWD_RF : fwd_b_int;
    stall     = stall_int && !rst;
    mc_issue  = issue_int && !rst;
    mc_done   = done_int && !rst;
    mc_busy   = busy_q;
    mc_dst    = dst_q;
    stall_cnt = stall_cnt_q;
  end

  // Scoreboard next state: load on issue, count down while busy, and
  // release at the edge that ends the mc_done cycle. dst is kept after
  // release; it is only meaningful while busy.
  always_comb begin
    busy_d = busy_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    if (issue_int) begin
      busy_d = 1'b1;
      dst_d  = id_wr_addr;
      cnt_d  = LAT;
    end else if (busy_q) begin
      if (done_int) begin
        busy_d = 1'b0;
        cnt_d  = 4'd0;
      end else begin
        cnt_d  = cnt_q - 4'd1;
      end
    end
  end

  // Stall performance counter, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CW'(1);
    end
  end

  // State registers; reset abandons any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      dst_q       <= '0;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
